// File: rtl/fir_pkg.sv
// Shared definitions for the symmetric FIR core and its result stream stage:
// FSM state encoding and default sample width / frame length.
package fir_pkg;

    localparam int FIR_DATA_WIDTH = 16;
    localparam int FIR_DATA_NUM   = 256;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/fir_sync_fifo.sv
// Synchronous FIFO with flush; head entry is read combinationally.
// Ports: clk, rst_n, flush, push, pop, din, dout, full, empty.
module fir_sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit separates full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/fir_result_stream.sv
// Converts FIR result write strobes into one valid/ready frame with tlast,
// tracking frame completion, sequence errors and FIFO overflow.
// Ports: clk, rst_n, wr_addr_i/wr_data_i/wr_we_i (core writes), done_intr_i,
//   clr_i (rearm), m_tdata_o/m_tvalid_o/m_tready_i/m_tlast_o (stream),
//   frame_done_o, overflow_o, seq_err_o, peak_o.
// Optional: define FIR_STREAM_STATS_EN to build the peak |sample| tracker.
module fir_result_stream
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = FIR_DATA_WIDTH,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_NUM   = FIR_DATA_NUM,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  wr_we_i,
    input  logic                  done_intr_i,
    input  logic                  clr_i,
    output logic [DATA_WIDTH-1:0] m_tdata_o,
    output logic                  m_tvalid_o,
    input  logic                  m_tready_i,
    output logic                  m_tlast_o,
    output logic                  frame_done_o,
    output logic                  overflow_o,
    output logic                  seq_err_o,
    output logic [DATA_WIDTH-1:0] peak_o
);

    localparam int CNT_W = $clog2(DATA_NUM) + 1;

    state_t                state;
    state_t                state_nx;
    logic [ADDR_WIDTH-1:0] exp_addr;
    logic [CNT_W-1:0]      count;
    logic                  done_d;
    logic [DATA_WIDTH:0]   head;
    logic                  full;
    logic                  empty;
    logic                  collecting;
    logic                  collect_wr;
    logic                  is_last;
    logic                  push;
    logic                  pop;

    assign collecting = (state == IDLE) || (state == COLLECT);
    assign collect_wr = wr_we_i && !clr_i && collecting;
    assign is_last    = (count == CNT_W'(DATA_NUM - 1));
    assign pop        = m_tvalid_o && m_tready_i;
    // A write into a full FIFO lands only when a beat leaves the same cycle.
    assign push       = collect_wr && (!full || pop);

    fir_sync_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (clr_i),
        .push  (push),
        .pop   (pop),
        .din   ({is_last, wr_data_i}),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign m_tvalid_o   = !empty;
    assign m_tdata_o    = empty ? '0 : head[DATA_WIDTH-1:0];
    assign m_tlast_o    = !empty && head[DATA_WIDTH];
    assign frame_done_o = (state == DRAIN) && pop && head[DATA_WIDTH] && !clr_i;

    always_comb begin
        state_nx = state;
        if (clr_i) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE, COLLECT: begin
                    if (wr_we_i) state_nx = is_last ? DRAIN : COLLECT;
                end
                DRAIN: begin
                    if (frame_done_o) state_nx = DONE;
                end
                DONE: begin
                    state_nx = DONE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            exp_addr   <= '0;
            count      <= '0;
            done_d     <= 1'b0;
            overflow_o <= 1'b0;
            seq_err_o  <= 1'b0;
        end else begin
            state  <= state_nx;
            done_d <= done_intr_i;
            if (clr_i) begin
                exp_addr   <= '0;
                count      <= '0;
                overflow_o <= 1'b0;
                seq_err_o  <= 1'b0;
            end else begin
                if (collect_wr) begin
                    exp_addr <= exp_addr + ADDR_WIDTH'(1);
                    count    <= count + CNT_W'(1);
                    if (wr_addr_i != exp_addr) seq_err_o <= 1'b1;
                    if (!push) overflow_o <= 1'b1;
                end
                if (wr_we_i && !collecting) seq_err_o <= 1'b1;
                // Completion before the frame is full means a short frame.
                if (done_intr_i && !done_d && collecting) seq_err_o <= 1'b1;
            end
        end
    end

`ifdef FIR_STREAM_STATS_EN
    logic [DATA_WIDTH-1:0] mag;
    logic [DATA_WIDTH-1:0] peak_q;

    // Saturating |x|: the most negative value maps to the largest positive.
    always_comb begin
        mag = wr_data_i;
        if (wr_data_i[DATA_WIDTH-1]) begin
            if (wr_data_i == {1'b1, {(DATA_WIDTH-1){1'b0}}}) begin
                mag = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            end else begin
                mag = -wr_data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_q <= '0;
        end else if (clr_i) begin
            peak_q <= '0;
        end else if (collect_wr && (mag > peak_q)) begin
            peak_q <= mag;
        end
    end

    assign peak_o = peak_q;
`else
    assign peak_o = '0;
`endif

endmodule

// File: tb/tb_fir_result_stream.sv
// Directed testbench for fir_result_stream: frame streaming, overflow,
// address skip, short frame, clear/rearm, peak statistic, mid-frame reset.
module tb_fir_result_stream;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int N  = 256;

`ifdef FIR_STREAM_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] wr_addr_i = '0;
    logic [DW-1:0] wr_data_i = '0;
    logic          wr_we_i = 1'b0;
    logic          done_intr_i = 1'b0;
    logic          clr_i = 1'b0;
    logic [DW-1:0] m_tdata_o;
    logic          m_tvalid_o;
    logic          m_tready_i = 1'b1;
    logic          m_tlast_o;
    logic          frame_done_o;
    logic          overflow_o;
    logic          seq_err_o;
    logic [DW-1:0] peak_o;

    fir_result_stream #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DATA_NUM   (N),
        .FIFO_DEPTH (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_addr_i    (wr_addr_i),
        .wr_data_i    (wr_data_i),
        .wr_we_i      (wr_we_i),
        .done_intr_i  (done_intr_i),
        .clr_i        (clr_i),
        .m_tdata_o    (m_tdata_o),
        .m_tvalid_o   (m_tvalid_o),
        .m_tready_i   (m_tready_i),
        .m_tlast_o    (m_tlast_o),
        .frame_done_o (frame_done_o),
        .overflow_o   (overflow_o),
        .seq_err_o    (seq_err_o),
        .peak_o       (peak_o)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int miss = 0;
    logic [DW:0] q[$];
    int fd_cnt = 0;

    // Inputs change at posedge+1, so the negedge sees the values that the
    // next posedge will act on.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_tvalid_o && m_tready_i) q.push_back({m_tlast_o, m_tdata_o});
            if (frame_done_o) fd_cnt++;
        end
    end

    task automatic wr(input int addr, input int data);
        wr_addr_i = AW'(addr);
        wr_data_i = DW'(data);
        wr_we_i   = 1'b1;
        @(posedge clk);
        #1;
        wr_we_i   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_pulse();
        clr_i = 1'b1;
        @(posedge clk);
        #1;
        clr_i = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        vecs++;
        if ({m_tvalid_o, m_tlast_o, frame_done_o, overflow_o, seq_err_o} !== 5'b0 ||
            m_tdata_o !== '0 || peak_o !== '0) begin
            miss++;
            $display("FAIL reset_outputs: got v=%b l=%b fd=%b ov=%b se=%b d=%h pk=%h want all 0",
                     m_tvalid_o, m_tlast_o, frame_done_o, overflow_o, seq_err_o, m_tdata_o, peak_o);
        end
        idle(2);
        rst_n = 1'b1;
        idle(2);
        vecs++;
        if (m_tvalid_o !== 1'b0 || seq_err_o !== 1'b0) begin
            miss++;
            $display("FAIL post_reset_idle: got v=%b se=%b want 0 0", m_tvalid_o, seq_err_o);
        end
    endtask

    task automatic test_full_frame();
        int base, fb, got, err;
        logic [DW:0] e;
        base = q.size();
        fb = fd_cnt;
        m_tready_i = 1'b1;
        for (int i = 0; i < N; i++) wr(i, i);
        idle(4);
        got = q.size() - base;
        vecs++;
        if (got !== N) begin
            miss++;
            $display("FAIL full_beats: got %0d want %0d", got, N);
        end
        err = 0;
        for (int k = 0; k < got && k < N; k++) begin
            e = {(k == N - 1), DW'(k)};
            if (q[base+k] !== e) err++;
        end
        vecs++;
        if (err !== 0) begin
            miss++;
            $display("FAIL full_order: got %0d bad beats want 0", err);
        end
        vecs++;
        if (fd_cnt - fb !== 1) begin
            miss++;
            $display("FAIL full_frame_done: got %0d pulses want 1", fd_cnt - fb);
        end
        vecs++;
        if (overflow_o !== 1'b0 || seq_err_o !== 1'b0) begin
            miss++;
            $display("FAIL full_flags: got ov=%b se=%b want 0 0", overflow_o, seq_err_o);
        end
        vecs++;
        if (peak_o !== (STATS ? DW'(255) : DW'(0))) begin
            miss++;
            $display("FAIL full_peak: got %h want %h", peak_o, STATS ? DW'(255) : DW'(0));
        end
        // A write after the frame completed is dropped and flagged.
        base = q.size();
        wr(0, 16'h5555);
        idle(2);
        vecs++;
        if (seq_err_o !== 1'b1 || q.size() !== base) begin
            miss++;
            $display("FAIL done_write: got se=%b beats=%0d want se=1 beats=0", seq_err_o, q.size() - base);
        end
        clr_pulse();
        vecs++;
        if (seq_err_o !== 1'b0 || overflow_o !== 1'b0 || peak_o !== '0 || m_tvalid_o !== 1'b0) begin
            miss++;
            $display("FAIL clr_flags: got se=%b ov=%b pk=%h v=%b want 0 0 0 0",
                     seq_err_o, overflow_o, peak_o, m_tvalid_o);
        end
    endtask

    task automatic test_overflow();
        int base, fb, got, err, idx;
        logic [DW:0] e;
        clr_pulse();
        base = q.size();
        fb = fd_cnt;
        m_tready_i = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i == 20) m_tready_i = 1'b1;
            wr(i, i);
        end
        idle(25);
        got = q.size() - base;
        vecs++;
        if (got !== N - 4) begin
            miss++;
            $display("FAIL ovf_beats: got %0d want %0d", got, N - 4);
        end
        err = 0;
        for (int k = 0; k < got && k < N - 4; k++) begin
            idx = (k < 16) ? k : k + 4;
            e = {(idx == N - 1), DW'(idx)};
            if (q[base+k] !== e) err++;
        end
        vecs++;
        if (err !== 0) begin
            miss++;
            $display("FAIL ovf_order: got %0d bad beats want 0", err);
        end
        vecs++;
        if (overflow_o !== 1'b1 || seq_err_o !== 1'b0 || fd_cnt - fb !== 1) begin
            miss++;
            $display("FAIL ovf_flags: got ov=%b se=%b fd=%0d want 1 0 1",
                     overflow_o, seq_err_o, fd_cnt - fb);
        end
    endtask

    task automatic test_seq_skip();
        int base, got, err;
        logic [DW:0] e;
        clr_pulse();
        base = q.size();
        m_tready_i = 1'b1;
        for (int i = 0; i < N; i++) begin
            wr((i < 5) ? i : i + 1, i);
            if (i == 4) begin
                vecs++;
                if (seq_err_o !== 1'b0) begin
                    miss++;
                    $display("FAIL skip_before: got se=%b want 0", seq_err_o);
                end
            end
            if (i == 5) begin
                vecs++;
                if (seq_err_o !== 1'b1) begin
                    miss++;
                    $display("FAIL skip_at6: got se=%b want 1", seq_err_o);
                end
            end
        end
        idle(4);
        got = q.size() - base;
        err = 0;
        for (int k = 0; k < got && k < N; k++) begin
            e = {(k == N - 1), DW'(k)};
            if (q[base+k] !== e) err++;
        end
        vecs++;
        if (got !== N || err !== 0 || seq_err_o !== 1'b1) begin
            miss++;
            $display("FAIL skip_stream: got beats=%0d bad=%0d se=%b want %0d 0 1",
                     got, err, seq_err_o, N);
        end
    endtask

    task automatic test_short_frame();
        int base, fb;
        clr_pulse();
        base = q.size();
        fb = fd_cnt;
        m_tready_i = 1'b1;
        for (int i = 0; i < 100; i++) wr(i, i);
        vecs++;
        if (seq_err_o !== 1'b0) begin
            miss++;
            $display("FAIL short_pre: got se=%b want 0", seq_err_o);
        end
        done_intr_i = 1'b1;
        idle(10);
        vecs++;
        if (seq_err_o !== 1'b1 || fd_cnt - fb !== 0 || q.size() - base !== 100) begin
            miss++;
            $display("FAIL short_frame: got se=%b fd=%0d beats=%0d want 1 0 100",
                     seq_err_o, fd_cnt - fb, q.size() - base);
        end
        done_intr_i = 1'b0;
        clr_pulse();
    endtask

    task automatic test_clr_second_frame();
        int base, fb, got, err;
        logic [DW-1:0] d;
        logic [DW:0] e;
        clr_pulse();
        base = q.size();
        fb = fd_cnt;
        m_tready_i = 1'b1;
        for (int i = 0; i < N; i++) begin
            d = (i == 10) ? 16'h8000 : (i == 20) ? 16'h7F00 : DW'(i * 3);
            wr(i, d);
        end
        idle(4);
        got = q.size() - base;
        err = 0;
        for (int k = 0; k < got && k < N; k++) begin
            d = (k == 10) ? 16'h8000 : (k == 20) ? 16'h7F00 : DW'(k * 3);
            e = {(k == N - 1), d};
            if (q[base+k] !== e) err++;
        end
        vecs++;
        if (got !== N || err !== 0 || fd_cnt - fb !== 1) begin
            miss++;
            $display("FAIL second_frame: got beats=%0d bad=%0d fd=%0d want %0d 0 1",
                     got, err, fd_cnt - fb, N);
        end
        vecs++;
        if (seq_err_o !== 1'b0 || overflow_o !== 1'b0) begin
            miss++;
            $display("FAIL second_flags: got se=%b ov=%b want 0 0", seq_err_o, overflow_o);
        end
        vecs++;
        if (peak_o !== (STATS ? 16'h7FFF : 16'h0000)) begin
            miss++;
            $display("FAIL peak_sat: got %h want %h", peak_o, STATS ? 16'h7FFF : 16'h0000);
        end
    endtask

    task automatic test_reset_mid_frame();
        clr_pulse();
        m_tready_i = 1'b0;
        for (int i = 0; i < 10; i++) wr(i, i + 16'h0100);
        vecs++;
        if (m_tvalid_o !== 1'b1 || m_tdata_o !== 16'h0100) begin
            miss++;
            $display("FAIL mid_pre: got v=%b d=%h want 1 0100", m_tvalid_o, m_tdata_o);
        end
        rst_n = 1'b0;
        #1;
        vecs++;
        if (m_tvalid_o !== 1'b0 || m_tdata_o !== '0 || m_tlast_o !== 1'b0) begin
            miss++;
            $display("FAIL mid_async: got v=%b d=%h l=%b want 0 0 0", m_tvalid_o, m_tdata_o, m_tlast_o);
        end
        idle(1);
        rst_n = 1'b1;
        idle(1);
        vecs++;
        if (m_tvalid_o !== 1'b0 || seq_err_o !== 1'b0 || overflow_o !== 1'b0) begin
            miss++;
            $display("FAIL mid_after: got v=%b se=%b ov=%b want 0 0 0", m_tvalid_o, seq_err_o, overflow_o);
        end
        m_tready_i = 1'b1;
        wr(0, 16'h1234);
        vecs++;
        if (m_tvalid_o !== 1'b1 || m_tdata_o !== 16'h1234 || seq_err_o !== 1'b0) begin
            miss++;
            $display("FAIL mid_restart: got v=%b d=%h se=%b want 1 1234 0", m_tvalid_o, m_tdata_o, seq_err_o);
        end
        idle(2);
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_overflow();
        test_seq_skip();
        test_short_frame();
        test_clr_second_frame();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
